// File: rtl/vm_tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : vm_tdm_demux
// Brief    : 4:1 TDM receive demultiplexer with slot select, frame
//            deserialisation and flywheel / loss-of-sync alignment tracking.
// Revision : 1.0 - initial release
// ============================================================================
module vm_tdm_demux #(
    parameter int MISS_MAX = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       din,
    input  logic       frame_sync,
    output logic [1:0] sel,
    output logic [3:0] q,
    output logic       valid,
    output logic       locked,
    output logic       sync_err
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_hunt = 2'd1;
    localparam logic [1:0] c_run  = 2'd2;

    localparam logic [2:0] c_miss_max = 3'(MISS_MAX);

    logic [1:0] r_state, w_state;
    logic [1:0] r_slot, w_slot;
    logic [3:0] r_shadow, w_shadow;
    logic [2:0] r_miss, w_miss;
    logic [3:0] r_q, w_q;
    logic       r_valid, w_valid;
    logic       r_sync_err, w_sync_err;
    logic [2:0] w_miss_inc;

    assign w_miss_inc = r_miss + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_idle;
            r_slot     <= 2'd0;
            r_shadow   <= 4'd0;
            r_miss     <= 3'd0;
            r_q        <= 4'd0;
            r_valid    <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_slot     <= w_slot;
            r_shadow   <= w_shadow;
            r_miss     <= w_miss;
            r_q        <= w_q;
            r_valid    <= w_valid;
            r_sync_err <= w_sync_err;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_slot     = r_slot;
        w_shadow   = r_shadow;
        w_miss     = r_miss;
        w_q        = r_q;
        w_valid    = 1'b0;
        w_sync_err = 1'b0;

        if (!en) begin
            // q deliberately holds so the last good word survives a disable
            w_state  = c_idle;
            w_slot   = 2'd0;
            w_miss   = 3'd0;
            w_shadow = 4'd0;
        end else begin
            case (r_state)
                c_idle: w_state = c_hunt;

                c_hunt: begin
                    if (frame_sync) begin
                        w_shadow = {3'd0, din};
                        w_slot   = 2'd1;
                        w_miss   = 3'd0;
                        w_state  = c_run;
                    end
                end

                c_run: begin
                    if (frame_sync && (r_slot != 2'd0)) begin
                        // Misaligned sync: drop the partial frame, restart at slot 0
                        w_sync_err = 1'b1;
                        w_shadow   = {3'd0, din};
                        w_slot     = 2'd1;
                        w_miss     = 3'd0;
                    end else if ((r_slot == 2'd0) && !frame_sync
                                 && (w_miss_inc == c_miss_max)) begin
                        w_state  = c_hunt;
                        w_slot   = 2'd0;
                        w_shadow = 4'd0;
                        w_miss   = 3'd0;
                    end else begin
                        w_shadow[r_slot] = din;
                        w_slot           = r_slot + 2'd1;
                        if (r_slot == 2'd0) begin
                            w_miss = frame_sync ? 3'd0 : w_miss_inc;
                        end
                        if (r_slot == 2'd3) begin
                            w_q     = {din, r_shadow[2:0]};
                            w_valid = 1'b1;
                        end
                    end
                end

                default: w_state = c_idle;
            endcase
        end
    end

    assign sel      = r_slot;
    assign q        = r_q;
    assign valid    = r_valid;
    assign locked   = (r_state == c_run);
    assign sync_err = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_vm_tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_vm_tdm_demux
// Brief    : Self-checking directed bench for vm_tdm_demux (MISS_MAX = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vm_tdm_demux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic       frame_sync = 1'b0;
    logic [1:0] sel;
    logic [3:0] q;
    logic       valid;
    logic       locked;
    logic       sync_err;

    int n_checks = 0;
    int n_errors = 0;

    vm_tdm_demux #(.MISS_MAX(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din        (din),
        .frame_sync (frame_sync),
        .sel        (sel),
        .q          (q),
        .valid      (valid),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, e, d, f;
        logic [1:0] sel;
        logic [3:0] q;
        logic       v, l, se;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, e, d, f, input logic [1:0] s,
                                input logic [3:0] qq, input logic v, l, se);
        vec_t t;
        t.r = r; t.e = e; t.d = d; t.f = f;
        t.sel = s; t.q = qq; t.v = v; t.l = l; t.se = se;
        tbl.push_back(t);
    endfunction

    // Inputs are applied just after a rising edge and outputs sampled 1 time unit after the next one
    task automatic step(input logic r, e, d, f);
        rst = r; en = e; din = d; frame_sync = f;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [1:0] s, input logic [3:0] qq,
                           input logic v, l, se);
        chk({name, ".sel"}, int'(sel), int'(s));
        chk({name, ".q"}, int'(q), int'(qq));
        chk({name, ".valid"}, int'(valid), int'(v));
        chk({name, ".locked"}, int'(locked), int'(l));
        chk({name, ".sync_err"}, int'(sync_err), int'(se));
    endtask

    // One frame starting at slot 0 (RUN, or HUNT when fs0=1); bits[k] is slot k
    task automatic run_frame(input string name, input logic [3:0] bits, input logic fs0,
                             input logic [3:0] q_prev, input logic [3:0] q_new);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, bits[k], (k == 0) ? fs0 : 1'b0);
            if (k < 3) chk_all($sformatf("%s[%0d]", name, k), 2'(k + 1), q_prev, 1'b0, 1'b1, 1'b0);
            else       chk_all($sformatf("%s[%0d]", name, k), 2'd0, q_new, 1'b1, 1'b1, 1'b0);
        end
    endtask

    initial begin
        //    r  e  d  f   sel   q     v  l  se
        add(1, 0, 0, 0, 2'd0, 4'h0, 0, 0, 0); // reset
        add(0, 1, 0, 0, 2'd0, 4'h0, 0, 0, 0); // IDLE -> HUNT
        add(0, 1, 1, 0, 2'd0, 4'h0, 0, 0, 0); // HUNT ignores din without sync
        add(0, 1, 1, 1, 2'd1, 4'h0, 0, 1, 0); // frame 1101
        add(0, 1, 0, 0, 2'd2, 4'h0, 0, 1, 0);
        add(0, 1, 1, 0, 2'd3, 4'h0, 0, 1, 0);
        add(0, 1, 1, 0, 2'd0, 4'hD, 1, 1, 0);
        add(0, 1, 0, 1, 2'd1, 4'hD, 0, 1, 0); // frame A
        add(0, 1, 1, 0, 2'd2, 4'hD, 0, 1, 0);
        add(0, 1, 0, 0, 2'd3, 4'hD, 0, 1, 0);
        add(0, 1, 1, 0, 2'd0, 4'hA, 1, 1, 0);
        add(0, 1, 1, 1, 2'd1, 4'hA, 0, 1, 0); // frame 5
        add(0, 1, 0, 0, 2'd2, 4'hA, 0, 1, 0);
        add(0, 1, 1, 0, 2'd3, 4'hA, 0, 1, 0);
        add(0, 1, 0, 0, 2'd0, 4'h5, 1, 1, 0);
        add(0, 1, 1, 1, 2'd1, 4'h5, 0, 1, 0); // frame F
        add(0, 1, 1, 0, 2'd2, 4'h5, 0, 1, 0);
        add(0, 1, 1, 0, 2'd3, 4'h5, 0, 1, 0);
        add(0, 1, 1, 0, 2'd0, 4'hF, 1, 1, 0);
        add(0, 1, 0, 1, 2'd1, 4'hF, 0, 1, 0); // sync at slot 2 aborts
        add(0, 1, 0, 0, 2'd2, 4'hF, 0, 1, 0);
        add(0, 1, 0, 1, 2'd1, 4'hF, 0, 1, 1); // realigned, bits 0,1,1,0
        add(0, 1, 1, 0, 2'd2, 4'hF, 0, 1, 0);
        add(0, 1, 1, 0, 2'd3, 4'hF, 0, 1, 0);
        add(0, 1, 0, 0, 2'd0, 4'h6, 1, 1, 0);
        add(0, 1, 1, 1, 2'd1, 4'h6, 0, 1, 0); // sync at slot 3 beats emit
        add(0, 1, 0, 0, 2'd2, 4'h6, 0, 1, 0);
        add(0, 1, 0, 0, 2'd3, 4'h6, 0, 1, 0);
        add(0, 1, 1, 1, 2'd1, 4'h6, 0, 1, 1);
        add(0, 1, 1, 0, 2'd2, 4'h6, 0, 1, 0);
        add(0, 1, 1, 0, 2'd3, 4'h6, 0, 1, 0);
        add(0, 1, 1, 0, 2'd0, 4'hF, 1, 1, 0);

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].f);
            chk_all($sformatf("vec%0d", i), tbl[i].sel, tbl[i].q, tbl[i].v, tbl[i].l, tbl[i].se);
        end

        // Flywheel: a sync between two single misses clears the miss count
        run_frame("fly1", 4'b0001, 1'b0, 4'hF, 4'h1);
        run_frame("resync", 4'b0010, 1'b1, 4'h1, 4'h2);
        run_frame("fly2", 4'b0100, 1'b0, 4'h2, 4'h4);

        // Second consecutive miss drops lock; rest of the frame is ignored
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk_all("loss", 2'd0, 4'h4, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            chk_all($sformatf("hunt%0d", k), 2'd0, 4'h4, 1'b0, 1'b0, 1'b0);
        end
        run_frame("relock", 4'b1110, 1'b1, 4'h4, 4'hE);

        // Disable mid-frame at slot 2, then re-enable
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk_all("en_s0", 2'd1, 4'hE, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk_all("en_s1", 2'd2, 4'hE, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("en_off", 2'd0, 4'hE, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("en_hunt", 2'd0, 4'hE, 1'b0, 1'b0, 1'b0);
        run_frame("reen", 4'b1001, 1'b1, 4'hE, 4'h9);

        // Reset at slot 1 clears q as well
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk_all("rst_s0", 2'd1, 4'h9, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("rst_mid", 2'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("rst_hunt", 2'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        run_frame("post_rst", 4'b1100, 1'b1, 4'h0, 4'hC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
